// File: rtl/egress_rate_limiter_pkg.sv
// Shared definitions for the egress token-bucket shaper: IOQ module header
// marker, location of the byte-length field in that header, FSM encoding.
package egress_rate_limiter_pkg;

   // ctrl value that tags the IOQ module header word
   localparam logic [7:0] ERL_IOQ_STAGE_NUM = 8'hff;

   // byte-length field inside the IOQ module header data word
   localparam int IOQ_LEN_MSB = 15;
   localparam int IOQ_LEN_LSB = 0;
   localparam int IOQ_LEN_W   = IOQ_LEN_MSB - IOQ_LEN_LSB + 1;

   // HDR: head word is the first word of a packet awaiting release
   // PASS: packet released, words stream out until end of packet
   typedef enum logic [0:0] {
      ST_HDR  = 1'b0,
      ST_PASS = 1'b1
   } erl_state_e;

endpackage

// File: rtl/egress_rate_limiter_fifo.sv
// Small fallthrough FIFO used as the shaper's input buffer. Words land in a
// RAM array and are prefetched into a head register, so the head word is
// presented without a read request and the output is always registered.
// nearly_full asserts when the array has a single free slot left.
module fallthrough_small_fifo #(
   parameter int WIDTH          = 72,
   parameter int MAX_DEPTH_BITS = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             wr_en,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             nearly_full
);

   localparam int DEPTH = 1 << MAX_DEPTH_BITS;
   localparam logic [MAX_DEPTH_BITS:0]   CNT_FULL = (MAX_DEPTH_BITS + 1)'(DEPTH);
   localparam logic [MAX_DEPTH_BITS:0]   CNT_NF   = (MAX_DEPTH_BITS + 1)'(DEPTH - 1);
   localparam logic [MAX_DEPTH_BITS:0]   CNT_ONE  = (MAX_DEPTH_BITS + 1)'(1);
   localparam logic [MAX_DEPTH_BITS-1:0] PTR_ONE  = MAX_DEPTH_BITS'(1);

   logic [WIDTH-1:0]          mem [DEPTH];
   logic [MAX_DEPTH_BITS-1:0] wr_ptr;
   logic [MAX_DEPTH_BITS-1:0] rd_ptr;
   logic [MAX_DEPTH_BITS:0]   mem_cnt;
   logic                      head_vld;
   logic [WIDTH-1:0]          head_data;
   logic                      do_wr;
   logic                      do_pop;
   logic                      do_fetch;

   // Accept writes while the array has room; refill the head register when it is empty or being popped.
   always_comb begin
      do_wr    = wr_en && (mem_cnt != CNT_FULL);
      do_pop   = rd_en && head_vld;
      do_fetch = (mem_cnt != '0) && (!head_vld || do_pop);
   end

   // Storage array write port (data only, never reset).
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= din;
      end
   end

   // Head register load from the array (data only, never reset).
   always_ff @(posedge clk) begin
      if (do_fetch) begin
         head_data <= mem[rd_ptr];
      end
   end

   // Pointers, array occupancy and head-valid flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         mem_cnt  <= '0;
         head_vld <= 1'b0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_fetch) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({do_wr, do_fetch})
            2'b10:   mem_cnt <= mem_cnt + CNT_ONE;
            2'b01:   mem_cnt <= mem_cnt - CNT_ONE;
            default: mem_cnt <= mem_cnt;
         endcase
         if (do_fetch) begin
            head_vld <= 1'b1;
         end else if (do_pop) begin
            head_vld <= 1'b0;
         end
      end
   end

   assign dout        = head_data;
   assign empty       = !head_vld;
   assign nearly_full = (mem_cnt >= CNT_NF);

endmodule

// File: rtl/egress_rate_limiter.sv
// Per-port token-bucket egress shaper. Words from the output queue are
// buffered in a fallthrough FIFO; a packet is released as a whole once the
// bucket holds at least the byte length carried in its IOQ module header.
// Packets are never split or dropped. With cfg_enable low the block is
// transparent and the bucket is held at its ceiling.
// Optional build macro ERL_STATS_EN adds stat_pkts/stat_bytes/stat_stall_cycles.
module egress_rate_limiter
   import egress_rate_limiter_pkg::*;
#(
   parameter int                    DATA_WIDTH      = 64,
   parameter int                    CTRL_WIDTH      = DATA_WIDTH / 8,
   parameter logic [CTRL_WIDTH-1:0] IOQ_STAGE_NUM   = CTRL_WIDTH'(ERL_IOQ_STAGE_NUM),
   parameter int                    TOKEN_WIDTH     = 20,
   parameter int                    FIFO_DEPTH_BITS = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [DATA_WIDTH-1:0]  in_data,
   input  logic [CTRL_WIDTH-1:0]  in_ctrl,
   input  logic                   in_wr,
   output logic                   in_rdy,
   output logic [DATA_WIDTH-1:0]  out_data,
   output logic [CTRL_WIDTH-1:0]  out_ctrl,
   output logic                   out_wr,
   input  logic                   out_rdy,
   input  logic                   cfg_enable,
   input  logic [15:0]            cfg_inc,
   input  logic [15:0]            cfg_interval,
   input  logic [TOKEN_WIDTH-1:0] cfg_bucket_max
`ifdef ERL_STATS_EN
   ,
   output logic [31:0]            stat_pkts,
   output logic [31:0]            stat_bytes,
   output logic [31:0]            stat_stall_cycles
`endif
);

   localparam int WORD_W = DATA_WIDTH + CTRL_WIDTH;
   // bucket arithmetic width: room for tokens + increment and for a negative difference
   localparam int SUM_W  = TOKEN_WIDTH + 2;

   logic [WORD_W-1:0]      fifo_dout;
   logic                   fifo_empty;
   logic                   fifo_nearly_full;
   logic                   fifo_wr;
   logic                   fifo_rd;
   logic [DATA_WIDTH-1:0]  head_data;
   logic [CTRL_WIDTH-1:0]  head_ctrl;

   erl_state_e             state;
   erl_state_e             state_next;
   logic                   data_seen;
   logic                   eop;

   logic [TOKEN_WIDTH-1:0] tokens;
   logic [15:0]            tick_cnt;
   logic [15:0]            interval_eff;
   logic                   tick;

   logic [IOQ_LEN_W-1:0]   hdr_len;
   logic [IOQ_LEN_W-1:0]   deduct;
   logic                   tokens_ok;
   logic                   hdr_go;

   logic [SUM_W-1:0]       tok_w;
   logic [SUM_W-1:0]       len_w;
   logic [SUM_W-1:0]       max_w;
   logic [SUM_W-1:0]       ded_w;
   logic [SUM_W-1:0]       inc_w;
   logic signed [SUM_W-1:0] sum_s;

   // Clamp the bucket update into [0, ceiling].
   function automatic logic [TOKEN_WIDTH-1:0] sat_tokens(
      input logic signed [SUM_W-1:0] v,
      input logic [TOKEN_WIDTH-1:0]  ceil_val
   );
      logic signed [SUM_W-1:0] ceil_s;
      ceil_s = $signed({2'b00, ceil_val});
      if (v[SUM_W-1]) begin
         sat_tokens = '0;
      end else if (v > ceil_s) begin
         sat_tokens = ceil_val;
      end else begin
         sat_tokens = v[TOKEN_WIDTH-1:0];
      end
   endfunction

   assign in_rdy  = !reset && !fifo_nearly_full;
   assign fifo_wr = in_wr && in_rdy;

   fallthrough_small_fifo #(
      .WIDTH          (WORD_W),
      .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
   ) u_in_fifo (
      .clk         (clk),
      .reset       (reset),
      .din         ({in_data, in_ctrl}),
      .wr_en       (fifo_wr),
      .rd_en       (fifo_rd),
      .dout        (fifo_dout),
      .empty       (fifo_empty),
      .nearly_full (fifo_nearly_full)
   );

   assign head_data = fifo_dout[WORD_W-1:CTRL_WIDTH];
   assign head_ctrl = fifo_dout[CTRL_WIDTH-1:0];

   // Release decision for the packet whose first word sits at the FIFO head.
   // A packet longer than the ceiling can never be fully covered, so it goes once the bucket is full.
   always_comb begin
      hdr_len   = (head_ctrl == IOQ_STAGE_NUM) ? head_data[IOQ_LEN_MSB:IOQ_LEN_LSB] : '0;
      tok_w     = SUM_W'(tokens);
      len_w     = SUM_W'(hdr_len);
      max_w     = SUM_W'(cfg_bucket_max);
      tokens_ok = (tok_w >= len_w) || ((len_w > max_w) && (tok_w >= max_w));
      hdr_go    = (state == ST_HDR) && !fifo_empty && (!cfg_enable || tokens_ok);
      deduct    = (hdr_go && cfg_enable) ? hdr_len : '0;
   end

   // Refill tick generator; an interval of 0 behaves like 1.
   always_comb begin
      interval_eff = (cfg_interval == 16'd0) ? 16'd1 : cfg_interval;
      tick         = (tick_cnt >= (interval_eff - 16'd1));
   end

   // Tick counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 16'd1;
      end
   end

   // Bucket update: deduction and refill in the same cycle both apply before clamping.
   always_comb begin
      ded_w = SUM_W'(deduct);
      inc_w = tick ? SUM_W'(cfg_inc) : '0;
      sum_s = $signed(tok_w - ded_w + inc_w);
   end

   // Token bucket register; held at the ceiling while shaping is disabled.
   always_ff @(posedge clk) begin
      if (reset || !cfg_enable) begin
         tokens <= cfg_bucket_max;
      end else begin
         tokens <= sat_tokens(sum_s, cfg_bucket_max);
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_HDR;
      end else begin
         state <= state_next;
      end
   end

   // FSM next state: release moves to PASS, end of packet returns to HDR.
   always_comb begin
      state_next = state;
      case (state)
         ST_HDR:  if (hdr_go) state_next = ST_PASS;
         ST_PASS: if (eop)    state_next = ST_HDR;
         default:             state_next = ST_HDR;
      endcase
   end

   // FSM outputs: in PASS the FIFO head streams straight to the MAC queue.
   always_comb begin
      out_wr   = (state == ST_PASS) && !fifo_empty && out_rdy;
      out_data = head_data;
      out_ctrl = head_ctrl;
      fifo_rd  = out_wr;
      // a non-zero ctrl after payload has been seen closes the packet; module headers precede payload
      eop      = out_wr && (head_ctrl != '0) && data_seen;
   end

   // Payload-seen flag used to tell module headers apart from the end-of-packet word.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_seen <= 1'b0;
      end else if (eop) begin
         data_seen <= 1'b0;
      end else if (out_wr && (head_ctrl == '0)) begin
         data_seen <= 1'b1;
      end
   end

`ifdef ERL_STATS_EN
   logic hdr_stall;

   // A header is stalled when it is present in HDR but the bucket does not cover it.
   always_comb begin
      hdr_stall = (state == ST_HDR) && !fifo_empty && !hdr_go;
   end

   // Statistics counters, free-running with natural wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_pkts         <= '0;
         stat_bytes        <= '0;
         stat_stall_cycles <= '0;
      end else begin
         if (hdr_go) begin
            stat_pkts  <= stat_pkts + 32'd1;
            stat_bytes <= stat_bytes + 32'(hdr_len);
         end
         if (hdr_stall) begin
            stat_stall_cycles <= stat_stall_cycles + 32'd1;
         end
      end
   end
`endif

endmodule
